// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bus bit positions, access size
// codes and the byte-lane helpers used by the MEM stage.
package mips_pkg;

    // mem_ctl bit positions ([7:5] are reserved)
    localparam int MEM_READ     = 0;
    localparam int MEM_WRITE    = 1;
    localparam int MEM_SIZE_LO  = 2;
    localparam int MEM_SIZE_HI  = 3;
    localparam int MEM_UNSIGNED = 4;

    // wb_ctl bit positions
    localparam int WB_REG_WRITE  = 0;
    localparam int WB_MEM_TO_REG = 1;

    // Access size codes; 2'b11 is not named and behaves as a word.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    // Byte offset inside the word after masking to natural alignment.
    function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
        if (size == SZ_BYTE)      return off;
        else if (size == SZ_HALF) return {off[1], 1'b0};
        else                      return 2'b00;
    endfunction

    // Byte-lane write mask for an access of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        if (size == SZ_BYTE)      return 4'b0001 << off;
        else if (size == SZ_HALF) return off[1] ? 4'b1100 : 4'b0011;
        else                      return 4'b1111;
    endfunction

endpackage

// File: rtl/data_ram.sv
// Synchronous single-port data RAM with per-byte write enables and a
// registered read port. The read register only updates while i_re is high,
// so a stalled pipeline keeps presenting the same load data.
module data_ram #(
    parameter int NB_BITS = 32,
    parameter int NB_ADDR = 10
) (
    input  logic               i_clk,
    input  logic [3:0]         i_be,
    input  logic               i_re,
    input  logic [NB_ADDR-1:0] i_addr,
    input  logic [NB_BITS-1:0] i_wdata,
    output logic [NB_BITS-1:0] o_rdata
);

    logic [NB_BITS-1:0] mem_q [0:(1 << NB_ADDR)-1];
    logic [NB_BITS-1:0] rdata_q;
    logic [NB_BITS-1:0] rdata_d;

    // Next read-register value: fresh word when enabled, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (i_re) rdata_d = mem_q[i_addr];
    end

    // Byte-lane writes and the read register share the one rising edge.
    always_ff @(posedge i_clk) begin
        rdata_q <= rdata_d;
        for (int i = 0; i < 4; i++) begin
            if (i_be[i]) mem_q[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: loads/stores against data_ram, MEM/WB pipeline registers
// and the MEM/WB forwarding value.
// Optional feature macro: MEM_MISALIGN_CHECK_EN. When defined, misaligned
// half/word accesses fault (store dropped, load data 0, o_misaligned=1);
// otherwise the low address bits are masked to natural alignment.
// Pipeline contract: there is no valid/ready pair; i_stall=1 means "this
// cycle does not advance" -- every MEM/WB register and the RAM read register
// hold, no store commits, and upstream keeps its inputs stable.
module memory_stage
    import mips_pkg::*;
#(
    parameter int NB_BITS = 32,
    parameter int NB_ADDR = 10,
    parameter int NB_CTL  = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_BITS-1:0] i_alu_out,
    input  logic [NB_BITS-1:0] i_data_reg,
    input  logic [4:0]         i_reg_dst,
    input  logic [NB_CTL-1:0]  i_wb_ctl,
    input  logic [NB_CTL-1:0]  i_mem_ctl,
    input  logic               i_stall,
    output logic [NB_BITS-1:0] o_mem_data,
    output logic [NB_BITS-1:0] o_alu_out,
    output logic [4:0]         o_reg_dst,
    output logic [NB_CTL-1:0]  o_wb_ctl,
    output logic [NB_BITS-1:0] o_mem_wb_reg_hz,
    output logic               o_misaligned
);

    logic               rd, wr, fault;
    logic [1:0]         size, off;
    logic [3:0]         be;
    logic [NB_BITS-1:0] wdata, rdata;

    logic [NB_BITS-1:0] alu_out_q, alu_out_d;
    logic [4:0]         reg_dst_q, reg_dst_d;
    logic [NB_CTL-1:0]  wb_ctl_q, wb_ctl_d;
    logic               load_q, load_d;
    logic               uns_q, uns_d;
    logic               mis_q, mis_d;
    logic [1:0]         size_q, size_d;
    logic [1:0]         off_q, off_d;

    logic               unused_bits;
    assign unused_bits = ^{i_alu_out[NB_BITS-1:NB_ADDR+2], i_mem_ctl[NB_CTL-1:5]};

    // Decode the access, check alignment and steer store data onto lanes.
    always_comb begin
        rd    = i_mem_ctl[MEM_READ];
        wr    = i_mem_ctl[MEM_WRITE];
        size  = i_mem_ctl[MEM_SIZE_HI:MEM_SIZE_LO];
        off   = align_offset(size, i_alu_out[1:0]);
`ifdef MEM_MISALIGN_CHECK_EN
        fault = (rd || wr) && (off != i_alu_out[1:0]);
`else
        fault = 1'b0;
`endif
        if (size == SZ_BYTE)      wdata = {4{i_data_reg[7:0]}};
        else if (size == SZ_HALF) wdata = {2{i_data_reg[15:0]}};
        else                      wdata = i_data_reg;
        be = 4'b0000;
        if (wr && !i_stall && !i_rst && !fault) be = lane_mask(size, off);
    end

    data_ram #(
        .NB_BITS (NB_BITS),
        .NB_ADDR (NB_ADDR)
    ) u_data_ram (
        .i_clk   (i_clk),
        .i_be    (be),
        .i_re    (!i_stall),
        .i_addr  (i_alu_out[NB_ADDR+1:2]),
        .i_wdata (wdata),
        .o_rdata (rdata)
    );

    // Next MEM/WB register values: capture the instruction unless stalled.
    always_comb begin
        alu_out_d = alu_out_q;
        reg_dst_d = reg_dst_q;
        wb_ctl_d  = wb_ctl_q;
        load_d    = load_q;
        uns_d     = uns_q;
        mis_d     = mis_q;
        size_d    = size_q;
        off_d     = off_q;
        if (!i_stall) begin
            alu_out_d = i_alu_out;
            reg_dst_d = i_reg_dst;
            wb_ctl_d  = i_wb_ctl;
            load_d    = rd && !wr && !fault;
            uns_d     = i_mem_ctl[MEM_UNSIGNED];
            mis_d     = fault;
            size_d    = size;
            off_d     = off;
        end
    end

    // MEM/WB registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            alu_out_q <= '0;
            reg_dst_q <= '0;
            wb_ctl_q  <= '0;
            load_q    <= 1'b0;
            uns_q     <= 1'b0;
            mis_q     <= 1'b0;
            size_q    <= 2'b00;
            off_q     <= 2'b00;
        end else begin
            alu_out_q <= alu_out_d;
            reg_dst_q <= reg_dst_d;
            wb_ctl_q  <= wb_ctl_d;
            load_q    <= load_d;
            uns_q     <= uns_d;
            mis_q     <= mis_d;
            size_q    <= size_d;
            off_q     <= off_d;
        end
    end

    // Pick the loaded lane(s) from the read word and extend to full width.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off_q, 3'b000} +: 8];
        h = off_q[1] ? rdata[31:16] : rdata[15:0];
        o_mem_data = '0;
        if (load_q) begin
            if (size_q == SZ_BYTE)
                o_mem_data = uns_q ? {{(NB_BITS-8){1'b0}}, b} : {{(NB_BITS-8){b[7]}}, b};
            else if (size_q == SZ_HALF)
                o_mem_data = uns_q ? {{(NB_BITS-16){1'b0}}, h} : {{(NB_BITS-16){h[15]}}, h};
            else
                o_mem_data = rdata;
        end
    end

    assign o_alu_out       = alu_out_q;
    assign o_reg_dst       = reg_dst_q;
    assign o_wb_ctl        = wb_ctl_q;
    assign o_misaligned    = mis_q;
    assign o_mem_wb_reg_hz = wb_ctl_q[WB_MEM_TO_REG] ? o_mem_data : alu_out_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: byte-addressed reference memory, per-cycle
// expected-output queue with one compare process, directed spot checks
// against literal values, then randomized traffic.
module tb_memory_stage;

    localparam int W = 110;  // {mem_data, alu_out, reg_dst, wb_ctl, hz, misaligned}

    localparam logic [7:0] LW  = 8'h09;
    localparam logic [7:0] SW  = 8'h0A;
    localparam logic [7:0] LB  = 8'h01;
    localparam logic [7:0] LBU = 8'h11;
    localparam logic [7:0] LH  = 8'h05;
    localparam logic [7:0] LHU = 8'h15;
    localparam logic [7:0] SB  = 8'h02;
    localparam logic [7:0] SH  = 8'h06;

    // clock / reset signals
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        i_rst, i_stall;
    logic [31:0] i_alu_out, i_data_reg;
    logic [4:0]  i_reg_dst;
    logic [7:0]  i_wb_ctl, i_mem_ctl;
    logic [31:0] o_mem_data, o_alu_out, o_mem_wb_reg_hz;
    logic [4:0]  o_reg_dst;
    logic [7:0]  o_wb_ctl;
    logic        o_misaligned;

    memory_stage dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_alu_out       (i_alu_out),
        .i_data_reg      (i_data_reg),
        .i_reg_dst       (i_reg_dst),
        .i_wb_ctl        (i_wb_ctl),
        .i_mem_ctl       (i_mem_ctl),
        .i_stall         (i_stall),
        .o_mem_data      (o_mem_data),
        .o_alu_out       (o_alu_out),
        .o_reg_dst       (o_reg_dst),
        .o_wb_ctl        (o_wb_ctl),
        .o_mem_wb_reg_hz (o_mem_wb_reg_hz),
        .o_misaligned    (o_misaligned)
    );

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // reference model: byte memory (4 KiB wraps exactly like the RAM) + stage outputs
    logic [7:0]  mem_b [0:4095];
    logic [31:0] m_data = '0, m_alu = '0;
    logic [4:0]  m_dst = '0;
    logic [7:0]  m_wb = '0;
    logic        m_mis = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic stall, input logic [31:0] alu,
                              input logic [31:0] data, input logic [4:0] dst,
                              input logic [7:0] wb, input logic [7:0] mc);
        int n;
        int base;
        logic f;
        logic [31:0] v;
        if (rst) begin
            m_data = '0; m_alu = '0; m_dst = '0; m_wb = '0; m_mis = 1'b0;
        end else if (!stall) begin
            n = (mc[3:2] == 2'b00) ? 1 : (mc[3:2] == 2'b01) ? 2 : 4;
            f = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            f = (mc[0] || mc[1]) && ((int'(alu[1:0]) % n) != 0);
`endif
            base = int'(alu[11:0]) & ~(n - 1);
            v = '0;
            if (mc[1]) begin
                if (!f) for (int i = 0; i < n; i++) mem_b[base + i] = data[8*i +: 8];
            end else if (mc[0] && !f) begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = mem_b[base + i];
                if (!mc[4] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            end
            m_data = v; m_alu = alu; m_dst = dst; m_wb = wb; m_mis = f;
        end
    endtask

    // driver: apply one cycle of inputs, queue what the outputs must be after the edge
    task automatic drive(input logic rst, input logic stall, input logic [31:0] alu,
                         input logic [31:0] data, input logic [4:0] dst,
                         input logic [7:0] wb, input logic [7:0] mc);
        @(negedge clk);
        i_rst = rst; i_stall = stall; i_alu_out = alu; i_data_reg = data;
        i_reg_dst = dst; i_wb_ctl = wb; i_mem_ctl = mc;
        model_step(rst, stall, alu, data, dst, wb, mc);
        exp_q.push_back({m_data, m_alu, m_dst, m_wb, (m_wb[1] ? m_data : m_alu), m_mis});
        @(posedge clk);
    endtask

    // compare process: every cycle that has an expectation queued
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mem_data", o_mem_data, e[109:78]);
                check("alu_out", o_alu_out, e[77:46]);
                check("reg_dst", {27'd0, o_reg_dst}, {27'd0, e[45:41]});
                check("wb_ctl", {24'd0, o_wb_ctl}, {24'd0, e[40:33]});
                check("mem_wb_reg_hz", o_mem_wb_reg_hz, e[32:1]);
                check("misaligned", {31'd0, o_misaligned}, {31'd0, e[0]});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst = 1'b1; i_stall = 1'b0; i_alu_out = '0; i_data_reg = '0;
        i_reg_dst = '0; i_wb_ctl = '0; i_mem_ctl = '0;

        drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        #2;
        check("lit_reset_hz", o_mem_wb_reg_hz, 32'h0);
        check("lit_reset_dst", {27'd0, o_reg_dst}, 32'h0);

        // fill the first 64 words so every later load has known data
        for (int w = 0; w < 64; w++)
            drive(0, 0, w * 4, $urandom, 5'($urandom), 8'($urandom), SW);

        // reset with a store in flight: store suppressed, RAM kept
        drive(0, 0, 32'h18, 32'hCAFEF00D, 5'd3, 8'h00, SW);
        drive(1, 0, 32'h18, 32'hFFFFFFFF, 5'd7, 8'h03, SW);
        drive(1, 0, 32'h18, 32'hFFFFFFFF, 5'd7, 8'h03, SW);
        #2;
        check("lit_reset_alu", o_alu_out, 32'h0);
        check("lit_reset_wb", {24'd0, o_wb_ctl}, 32'h0);
        drive(0, 0, 32'h18, 0, 5'd4, 8'h03, LW);
        #2; check("lit_after_reset_lw", o_mem_data, 32'hCAFEF00D);

        // word store then load next cycle
        drive(0, 0, 32'h10, 32'hDEADBEEF, 5'd1, 8'h00, SW);
        drive(0, 0, 32'h10, 0, 5'd2, 8'h03, LW);
        #2;
        check("lit_lw_data", o_mem_data, 32'hDEADBEEF);
        check("lit_lw_hz", o_mem_wb_reg_hz, 32'hDEADBEEF);

        // byte/half extension
        drive(0, 0, 32'h20, 32'h80FF7F01, 5'd1, 8'h00, SW);
        drive(0, 0, 32'h23, 0, 5'd2, 8'h03, LB);
        #2; check("lit_lb", o_mem_data, 32'hFFFFFF80);
        drive(0, 0, 32'h23, 0, 5'd2, 8'h03, LBU);
        #2; check("lit_lbu", o_mem_data, 32'h00000080);
        drive(0, 0, 32'h22, 0, 5'd2, 8'h03, LH);
        #2; check("lit_lh", o_mem_data, 32'hFFFF80FF);
        drive(0, 0, 32'h20, 0, 5'd2, 8'h03, LHU);
        #2; check("lit_lhu", o_mem_data, 32'h00007F01);

        // sub-word store
        drive(0, 0, 32'h30, 32'h0, 5'd1, 8'h00, SW);
        drive(0, 0, 32'h31, 32'h123456AB, 5'd1, 8'h00, SB);
        drive(0, 0, 32'h30, 0, 5'd2, 8'h03, LW);
        #2; check("lit_sb_lw", o_mem_data, 32'h0000AB00);

        // stall: outputs frozen, store blocked until released
        drive(0, 0, 32'h40, 32'h11111111, 5'd1, 8'h00, SW);
        drive(0, 0, 32'h10, 0, 5'd2, 8'h03, LW);
        for (int k = 0; k < 3; k++) drive(0, 1, 32'h40, 32'h12345678, 5'd9, 8'h00, SW);
        #2;
        check("lit_stall_data", o_mem_data, 32'hDEADBEEF);
        check("lit_stall_alu", o_alu_out, 32'h10);
        drive(0, 0, 32'h40, 32'h12345678, 5'd9, 8'h00, SW);
        #2; check("lit_release_alu", o_alu_out, 32'h40);
        drive(0, 0, 32'h40, 0, 5'd2, 8'h03, LW);
        #2; check("lit_stall_lw", o_mem_data, 32'h12345678);

        // misaligned accesses
        drive(0, 0, 32'h40, 32'hA5A5A5A5, 5'd1, 8'h00, SW);
        drive(0, 0, 32'h42, 0, 5'd2, 8'h03, LW);
        #2;
`ifdef MEM_MISALIGN_CHECK_EN
        check("lit_mis_lw", o_mem_data, 32'h0);
        check("lit_mis_flag", {31'd0, o_misaligned}, 32'h1);
`else
        check("lit_mis_lw", o_mem_data, 32'hA5A5A5A5);
        check("lit_mis_flag", {31'd0, o_misaligned}, 32'h0);
`endif
        drive(0, 0, 32'h41, 32'h00007777, 5'd1, 8'h00, SH);
        drive(0, 0, 32'h40, 0, 5'd2, 8'h03, LW);
        #2;
`ifdef MEM_MISALIGN_CHECK_EN
        check("lit_mis_sh", o_mem_data, 32'hA5A5A5A5);
`else
        check("lit_mis_sh", o_mem_data, 32'hA5A57777);
`endif

        // randomized traffic inside the initialised window, random upper address bits
        for (int k = 0; k < 800; k++)
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255)),
                  $urandom, 5'($urandom), 8'($urandom), 8'($urandom_range(0, 255)));

        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expected 0 pending", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
